// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: ALU/branch codes,
// opcodes, instruction classes, FSM states and datapath mux selects.
package rv_ctrl_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] CL_R      = 3'd0;
    localparam logic [2:0] CL_I      = 3'd1;
    localparam logic [2:0] CL_LOAD   = 3'd2;
    localparam logic [2:0] CL_STORE  = 3'd3;
    localparam logic [2:0] CL_BRANCH = 3'd4;
    localparam logic [2:0] CL_JAL    = 3'd5;
    localparam logic [2:0] CL_JALR   = 3'd6;
    localparam logic [2:0] CL_LUI    = 3'd7;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_OPC  = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;
    localparam logic [1:0] A_PC   = 2'd3;

    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    localparam logic PC_ALU    = 1'b0;
    localparam logic PC_ALUOUT = 1'b1;

    // alt selects sub (R-type only) or sra; the caller qualifies it.
    function automatic logic [2:0] arith_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            3'b111:  arith_op = ALU_AND;
            default: arith_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction field decoder: classifies ir and derives the
// ALU op, branch condition, immediate format and legality for the FSM.
module cu_decode
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [2:0]  class_o,
    output logic [2:0]  alu_op_o,
    output logic [2:0]  br_ctrl_o,
    output logic [2:0]  imm_sel_o,
    output logic        legal_o
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       unused_bits;

    assign opcode      = ir_i[6:0];
    assign funct3      = ir_i[14:12];
    assign alt         = ir_i[30];
    assign unused_bits = ^{ir_i[31], ir_i[29:15], ir_i[11:7]};

    always_comb begin
        class_o   = CL_R;
        alu_op_o  = ALU_ADD;
        br_ctrl_o = BR_NONE;
        imm_sel_o = IMM_I;
        legal_o   = 1'b0;
        case (opcode)
            OP_R: begin
                class_o  = CL_R;
                alu_op_o = arith_op(funct3, alt);
                legal_o  = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OP_IMM: begin
                // funct7[5] on addi is just an immediate bit; only srai uses it.
                class_o  = CL_I;
                alu_op_o = arith_op(funct3, alt && (funct3 == 3'b101));
                legal_o  = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OP_LOAD: begin
                class_o = CL_LOAD;
                legal_o = 1'b1;
            end
            OP_STORE: begin
                class_o   = CL_STORE;
                imm_sel_o = IMM_S;
                legal_o   = 1'b1;
            end
            OP_BRANCH: begin
                class_o   = CL_BRANCH;
                alu_op_o  = ALU_SUB;
                imm_sel_o = IMM_B;
                legal_o   = 1'b1;
                case (funct3)
                    3'b000:  br_ctrl_o = BR_BEQ;
                    3'b001:  br_ctrl_o = BR_BNE;
                    3'b100:  br_ctrl_o = BR_BLT;
                    3'b101:  br_ctrl_o = BR_BGE;
                    default: legal_o   = 1'b0;
                endcase
            end
            OP_JAL: begin
                class_o   = CL_JAL;
                imm_sel_o = IMM_J;
                legal_o   = 1'b1;
            end
            OP_JALR: begin
                class_o = CL_JALR;
                legal_o = (funct3 == 3'b000);
            end
            OP_LUI: begin
                class_o   = CL_LUI;
                imm_sel_o = IMM_U;
                legal_o   = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb over a
// shared memory port and drives every datapath enable and mux select.
module multicycle_cu
    import rv_ctrl_pkg::*;
#(
    parameter bit RESET_TRAP = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ir_i,
    input  logic        mem_ready_i,
    input  logic        br_true_i,
    input  logic        trap_clr_i,
    output logic [2:0]  alu_op_o,
    output logic [2:0]  br_ctrl_o,
    output logic [1:0]  alu_a_sel_o,
    output logic [1:0]  alu_b_sel_o,
    output logic [2:0]  imm_sel_o,
    output logic [1:0]  wb_sel_o,
    output logic        pc_sel_o,
    output logic        iord_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        pc_we_o,
    output logic        opc_we_o,
    output logic        ir_we_o,
    output logic        alu_out_we_o,
    output logic        rf_we_o,
    output logic        illegal_o
);
    state_t     state_q, state_d;
    logic [2:0] dec_class, dec_alu_op, dec_br_ctrl, dec_imm_sel;
    logic       dec_legal;

    cu_decode u_decode (
        .ir_i      (ir_i),
        .class_o   (dec_class),
        .alu_op_o  (dec_alu_op),
        .br_ctrl_o (dec_br_ctrl),
        .imm_sel_o (dec_imm_sel),
        .legal_o   (dec_legal)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        alu_op_o     = ALU_ADD;
        br_ctrl_o    = BR_NONE;
        alu_a_sel_o  = A_RS1;
        alu_b_sel_o  = B_RS2;
        imm_sel_o    = IMM_I;
        wb_sel_o     = WB_ALU;
        pc_sel_o     = PC_ALU;
        iord_o       = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        pc_we_o      = 1'b0;
        opc_we_o     = 1'b0;
        ir_we_o      = 1'b0;
        alu_out_we_o = 1'b0;
        rf_we_o      = 1'b0;
        illegal_o    = 1'b0;
        // Everything stays at zero while reset is high, including mid-MEM.
        if (!rst_i) begin
            case (state_q)
                FETCH: begin
                    mem_req_o   = 1'b1;
                    alu_a_sel_o = A_PC;
                    alu_b_sel_o = B_FOUR;
                    if (mem_ready_i) begin
                        ir_we_o  = 1'b1;
                        opc_we_o = 1'b1;
                        pc_we_o  = 1'b1;
                        state_d  = DECODE;
                    end
                end
                DECODE: begin
                    // Speculative branch/jal target lands in alu_out.
                    alu_a_sel_o  = A_OPC;
                    alu_b_sel_o  = B_IMM;
                    alu_out_we_o = 1'b1;
                    if (dec_class == CL_BRANCH)   imm_sel_o = IMM_B;
                    else if (dec_class == CL_JAL) imm_sel_o = IMM_J;
                    state_d = dec_legal ? EXEC : TRAP;
                end
                EXEC: begin
                    imm_sel_o = dec_imm_sel;
                    alu_op_o  = dec_alu_op;
                    case (dec_class)
                        CL_R: begin
                            alu_out_we_o = 1'b1;
                            state_d      = WB;
                        end
                        CL_I, CL_LUI: begin
                            alu_a_sel_o  = (dec_class == CL_LUI) ? A_ZERO : A_RS1;
                            alu_b_sel_o  = B_IMM;
                            alu_out_we_o = 1'b1;
                            state_d      = WB;
                        end
                        CL_LOAD, CL_STORE: begin
                            alu_b_sel_o  = B_IMM;
                            alu_out_we_o = 1'b1;
                            state_d      = MEM;
                        end
                        CL_BRANCH: begin
                            br_ctrl_o = dec_br_ctrl;
                            pc_sel_o  = PC_ALUOUT;
                            pc_we_o   = br_true_i;
                            state_d   = FETCH;
                        end
                        CL_JAL: begin
                            pc_sel_o = PC_ALUOUT;
                            pc_we_o  = 1'b1;
                            rf_we_o  = 1'b1;
                            wb_sel_o = WB_PC;
                            state_d  = FETCH;
                        end
                        default: begin
                            alu_b_sel_o = B_IMM;
                            pc_we_o     = 1'b1;
                            rf_we_o     = 1'b1;
                            wb_sel_o    = WB_PC;
                            state_d     = FETCH;
                        end
                    endcase
                end
                MEM: begin
                    mem_req_o = 1'b1;
                    iord_o    = 1'b1;
                    mem_we_o  = (dec_class == CL_STORE);
                    if (mem_ready_i) begin
                        if (dec_class == CL_LOAD) begin
                            rf_we_o  = 1'b1;
                            wb_sel_o = WB_MEM;
                        end
                        state_d = FETCH;
                    end
                end
                WB: begin
                    rf_we_o = 1'b1;
                    state_d = FETCH;
                end
                TRAP: begin
                    illegal_o = 1'b1;
                    if (!RESET_TRAP && trap_clr_i) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: stimulus queues hand-computed per-cycle
// output vectors, a monitor pops and compares them on the falling edge.
module tb_multicycle_cu;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [2:0] br_ctrl;
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [2:0] imm_sel;
        logic [1:0] wb_sel;
        logic       pc_sel;
        logic       iord;
        logic       mem_req;
        logic       mem_we;
        logic       pc_we;
        logic       opc_we;
        logic       ir_we;
        logic       alu_out_we;
        logic       rf_we;
        logic       illegal;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b0;
    logic        br_true = 1'b0;
    logic        trap_clr = 1'b0;
    logic [2:0]  alu_op, br_ctrl, imm_sel;
    logic [1:0]  alu_a_sel, alu_b_sel, wb_sel;
    logic        pc_sel, iord, mem_req, mem_we, pc_we, opc_we, ir_we, alu_out_we, rf_we, illegal;
    outs_t       act;

    always #5 clk = ~clk;

    multicycle_cu #(.RESET_TRAP(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .ir_i(ir), .mem_ready_i(mem_ready),
        .br_true_i(br_true), .trap_clr_i(trap_clr),
        .alu_op_o(alu_op), .br_ctrl_o(br_ctrl), .alu_a_sel_o(alu_a_sel),
        .alu_b_sel_o(alu_b_sel), .imm_sel_o(imm_sel), .wb_sel_o(wb_sel),
        .pc_sel_o(pc_sel), .iord_o(iord), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .pc_we_o(pc_we), .opc_we_o(opc_we), .ir_we_o(ir_we),
        .alu_out_we_o(alu_out_we), .rf_we_o(rf_we), .illegal_o(illegal)
    );

    assign act = {alu_op, br_ctrl, alu_a_sel, alu_b_sel, imm_sel, wb_sel, pc_sel, iord,
                  mem_req, mem_we, pc_we, opc_we, ir_we, alu_out_we, rf_we, illegal};

    outs_t       exp_q[$];
    string       name_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] ir_cur = '0;

    // Expected-vector builders, one per FSM phase.
    function automatic outs_t o_zero();
        outs_t o = '0;
        return o;
    endfunction
    function automatic outs_t o_fetch(input logic rdy);
        outs_t o = '0;
        o.a_sel = 2'd3; o.b_sel = 2'd2; o.mem_req = 1'b1;
        o.ir_we = rdy; o.opc_we = rdy; o.pc_we = rdy;
        return o;
    endfunction
    function automatic outs_t o_dec(input logic [2:0] imm);
        outs_t o = '0;
        o.a_sel = 2'd1; o.b_sel = 2'd1; o.imm_sel = imm; o.alu_out_we = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_alu(input logic [1:0] a, input logic [1:0] b,
                                    input logic [2:0] imm, input logic [2:0] op);
        outs_t o = '0;
        o.a_sel = a; o.b_sel = b; o.imm_sel = imm; o.alu_op = op; o.alu_out_we = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_br(input logic [2:0] br, input logic bt);
        outs_t o = '0;
        o.alu_op = 3'd1; o.br_ctrl = br; o.imm_sel = 3'd2; o.pc_sel = 1'b1; o.pc_we = bt;
        return o;
    endfunction
    function automatic outs_t o_jump(input logic is_jal);
        outs_t o = '0;
        o.pc_we = 1'b1; o.rf_we = 1'b1; o.wb_sel = 2'd2;
        if (is_jal) begin o.pc_sel = 1'b1; o.imm_sel = 3'd4; end
        else        o.b_sel = 2'd1;
        return o;
    endfunction
    function automatic outs_t o_mem(input logic rdy, input logic ld, input logic st);
        outs_t o = '0;
        o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = st;
        if (ld && rdy) begin o.rf_we = 1'b1; o.wb_sel = 2'd1; end
        return o;
    endfunction
    function automatic outs_t o_wb();
        outs_t o = '0;
        o.rf_we = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_trap();
        outs_t o = '0;
        o.illegal = 1'b1;
        return o;
    endfunction

    task automatic step(input logic r, input logic rdy, input logic bt, input logic tc,
                        input outs_t e, input string n);
        @(posedge clk); #1;
        rst = r; ir = ir_cur; mem_ready = rdy; br_true = bt; trap_clr = tc;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // mem_ready is held high outside FETCH/MEM to show it is ignored there.
    task automatic run_arith(input logic [31:0] i, input logic [1:0] a, input logic [1:0] b,
                             input logic [2:0] imm, input logic [2:0] op, input string n);
        ir_cur = i;
        step(0, 1, 0, 0, o_fetch(1), {n, " fetch"});
        step(0, 1, 0, 0, o_dec(3'd0), {n, " decode"});
        step(0, 1, 0, 0, o_alu(a, b, imm, op), {n, " exec"});
        step(0, 1, 0, 0, o_wb(), {n, " wb"});
    endtask

    task automatic run_br(input logic [31:0] i, input logic [2:0] br, input logic bt,
                          input string n);
        ir_cur = i;
        step(0, 1, bt, 0, o_fetch(1), {n, " fetch"});
        step(0, 1, bt, 0, o_dec(3'd2), {n, " decode"});
        step(0, 1, bt, 0, o_br(br, bt), {n, " exec"});
    endtask

    task automatic run_trap_entry(input logic [31:0] i, input logic [2:0] dimm, input string n);
        ir_cur = i;
        step(0, 1, 0, 0, o_fetch(1), {n, " fetch"});
        step(0, 1, 0, 0, o_dec(dimm), {n, " decode"});
        step(0, 1, 0, 0, o_trap(), {n, " trap"});
    endtask

    initial begin : monitor
        outs_t e;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                tests++;
                if (act !== e)
                    begin
                        fails++;
                        $display("FAIL %s: got %h expected %h", n, act, e);
                    end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        step(1, 1, 1, 1, o_zero(), "reset gating");

        run_arith(32'h00500093, 2'd0, 2'd1, 3'd0, 3'd0, "addi");
        ir_cur = 32'h402081B3;
        step(0, 0, 0, 0, o_fetch(0), "sub fetch wait0");
        step(0, 0, 0, 0, o_fetch(0), "sub fetch wait1");
        run_arith(32'h402081B3, 2'd0, 2'd0, 3'd0, 3'd1, "sub");
        run_arith(32'h4020D1B3, 2'd0, 2'd0, 3'd0, 3'd7, "sra");
        run_arith(32'h0020D1B3, 2'd0, 2'd0, 3'd0, 3'd6, "srl");
        run_arith(32'h00106093, 2'd0, 2'd1, 3'd0, 3'd3, "ori");
        run_arith(32'hFFF00093, 2'd0, 2'd1, 3'd0, 3'd0, "addi neg");
        run_arith(32'h4010D093, 2'd0, 2'd1, 3'd0, 3'd7, "srai");
        run_arith(32'h123452B7, 2'd2, 2'd1, 3'd3, 3'd0, "lui");

        run_br(32'h00208463, 3'd1, 1'b1, "beq taken");
        run_br(32'h00208463, 3'd1, 1'b0, "beq not taken");
        run_br(32'h00209463, 3'd2, 1'b1, "bne");
        run_br(32'h0020C463, 3'd3, 1'b1, "blt");
        run_br(32'h0020D463, 3'd4, 1'b0, "bge");

        ir_cur = 32'h008000EF;
        step(0, 1, 0, 0, o_fetch(1), "jal fetch");
        step(0, 1, 0, 0, o_dec(3'd4), "jal decode");
        step(0, 1, 0, 0, o_jump(1'b1), "jal exec");
        ir_cur = 32'h000100E7;
        step(0, 1, 0, 0, o_fetch(1), "jalr fetch");
        step(0, 1, 0, 0, o_dec(3'd0), "jalr decode");
        step(0, 1, 0, 0, o_jump(1'b0), "jalr exec");

        ir_cur = 32'h0000A183;
        step(0, 1, 0, 0, o_fetch(1), "lw fetch");
        step(0, 1, 0, 0, o_dec(3'd0), "lw decode");
        step(0, 0, 0, 0, o_alu(2'd0, 2'd1, 3'd0, 3'd0), "lw exec");
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, o_mem(0, 1, 0), "lw mem wait");
        step(0, 1, 0, 0, o_mem(1, 1, 0), "lw mem ready");

        ir_cur = 32'h0020A023;
        step(0, 1, 0, 0, o_fetch(1), "sw fetch");
        step(0, 1, 0, 0, o_dec(3'd0), "sw decode");
        step(0, 0, 0, 0, o_alu(2'd0, 2'd1, 3'd1, 3'd0), "sw exec");
        step(0, 1, 0, 0, o_mem(1, 0, 1), "sw mem ready");
        step(0, 1, 0, 0, o_fetch(1), "sw2 fetch");
        step(0, 1, 0, 0, o_dec(3'd0), "sw2 decode");
        step(0, 0, 0, 0, o_alu(2'd0, 2'd1, 3'd1, 3'd0), "sw2 exec");
        step(0, 0, 0, 0, o_mem(0, 0, 1), "sw2 mem wait");
        step(1, 1, 0, 0, o_zero(), "rst mid mem");
        step(0, 0, 0, 0, o_fetch(0), "fetch after mem rst");

        run_trap_entry(32'h0000A033, 3'd0, "slt");
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, o_trap(), "slt trap hold");
        step(1, 0, 0, 0, o_zero(), "trap rst");
        step(0, 0, 0, 0, o_fetch(0), "fetch after trap rst");

        run_trap_entry(32'h00000000, 3'd0, "bad opcode");
        step(0, 0, 0, 1, o_trap(), "trap_clr cycle");
        step(0, 0, 0, 0, o_fetch(0), "fetch after trap_clr");

        run_trap_entry(32'h0020E463, 3'd2, "branch f3 110");
        step(0, 0, 0, 1, o_trap(), "branch trap_clr");
        step(0, 0, 0, 0, o_fetch(0), "fetch after branch trap");

        repeat (3) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
- Multi-cycle RV32I control unit. It is the producer side of the ALU control interface: it drives alu_op and br_ctrl, and consumes br_true.
- A Moore/Mealy FSM sequences FETCH, DECODE, EXEC, MEM and WB over a shared instruction/data memory port with a req/ready handshake.
- It drives all datapath enables and mux selects. It replaces the single-cycle decoder in the multi-cycle core.

Parameters:
- RESET_TRAP, 0, if 1, TRAP is left only by reset; if 0, TRAP also exits on the trap_clr input.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ir  in  32  instruction register contents
- mem_ready  in  1  memory completes the current request this cycle
- br_true  in  1  branch condition from the ALU, for the current br_ctrl
- trap_clr  in  1  leave TRAP (only used when RESET_TRAP=0)
- alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra
- br_ctrl  out  3  0 none, 1 beq, 2 bne, 3 blt, 4 bge
- alu_a_sel  out  2  0 rs1, 1 old_pc, 2 zero, 3 pc
- alu_b_sel  out  2  0 rs2, 1 imm, 2 const 4
- imm_sel  out  3  0 I, 1 S, 2 B, 3 U, 4 J
- wb_sel  out  2  0 alu_out reg, 1 mem_rdata, 2 pc (the link value)
- pc_sel  out  1  0 ALU result c, 1 alu_out reg
- iord  out  1  memory address: 0 pc, 1 alu_out
- mem_req / mem_we  out  1 / 1  memory request / write
- pc_we, opc_we, ir_we, alu_out_we, rf_we  out  1 each  register write enables
- illegal  out  1  high while in TRAP

Behaviour:
- Reset and output gating:
  - rst high at a clock edge: state <= FETCH.
  - While rst is high, all enables, mem_req, mem_we and illegal are 0, and all selects are 0.
  - Reset asserted mid-MEM drops mem_req in the same cycle. No write enable fires.
- Output timing: outputs decode combinationally from state, ir, mem_ready and br_true.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_a_sel=3, alu_b_sel=2, alu_op=add, pc_sel=0.
  - On mem_ready: ir_we, opc_we and pc_we are all 1 (the PC becomes pc+4), then go to DECODE.
  - Otherwise stay in FETCH, with every output held stable.
- DECODE:
  - alu_a_sel=1, alu_b_sel=1, alu_op=add, alu_out_we=1. imm_sel is B for branches, J for jal, I otherwise.
  - Illegal or unsupported encoding goes to TRAP; otherwise go to EXEC.
- EXEC, by instruction class:
  - R / I-arith: operands rs1 and rs2/imm(I); alu_op from funct3/funct7; alu_out_we=1; then WB.
  - LOAD / STORE: rs1 + imm(I or S), add, alu_out_we=1; then MEM.
  - BRANCH: rs1 - rs2 (alu_op=sub), br_ctrl from funct3, pc_sel=1, pc_we=br_true; then FETCH.
  - JAL: pc_sel=1, pc_we=1, rf_we=1, wb_sel=2; then FETCH.
  - JALR: rs1 + imm(I), pc_sel=0, pc_we=1, rf_we=1, wb_sel=2; then FETCH. The datapath clears bit 0 of the target.
  - LUI: zero + imm(U), alu_out_we=1; then WB.
- Write-before-update in the same edge: the register file captures the pre-update pc (pc+4) in the same edge the PC changes.
- MEM:
  - mem_req=1, iord=1, mem_we=1 for stores.
  - On mem_ready: a load asserts rf_we with wb_sel=1, then FETCH; a store goes to FETCH.
  - Otherwise stay in MEM, holding req, we and address.
- WB: rf_we=1, wb_sel=0; then FETCH.
- TRAP: illegal=1, all enables 0. Exit to FETCH only per RESET_TRAP.
- funct3 mapping for arithmetic:
  - 000: add, or sub when R-type and funct7[5]=1.
  - 001: sll. 100: xor. 110: or. 111: and.
  - 101: srl, or sra when funct7[5]=1.
  - 010 and 011 (slt/sltu) are unsupported and go to TRAP.
- funct3 mapping for branches:
  - 000 gives br_ctrl 1 (beq); 001 gives 2 (bne); 100 gives 3 (blt); 101 gives 4 (bge).
  - 110 and 111 go to TRAP.
  - blt/bge use the sign of the difference; signed overflow is a documented limitation.
- Illegal opcodes: anything other than 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111 and 0110111 goes to TRAP.
- Handshake rule: mem_req stays high from the state's first cycle until the cycle mem_ready is seen. mem_ready outside FETCH/MEM is ignored.
- CPI: R/I/LUI take 4 + fetch wait; load/store 4 + waits; branch/jal/jalr 3 + fetch wait.

Decomposition:
- Package rv_ctrl_pkg holds:
  - ALU op codes 0-7 and br_ctrl codes 0-4.
  - Opcode constants.
  - The state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP).
  - The mux-select encodings.
- Sub-module cu_decode: a purely combinational field decoder from ir to {class, alu_op, br_ctrl, imm_sel, legal}. The FSM in multicycle_cu consumes its outputs.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with mem_ready=1 each fetch cycle.
  - Response: FETCH→DECODE→EXEC(alu_a_sel=0, alu_b_sel=1, alu_op=0)→WB(rf_we=1, wb_sel=0)→FETCH.
- sub x3,x1,x2 (0x402081B3) gives alu_op=1 in EXEC. sra (0x4020D1B3) gives alu_op=7. srl (0x0020D1B3) gives alu_op=6.
- beq (funct3 000): EXEC br_ctrl=1, alu_op=1.
  - With br_true=1: pc_we=1, pc_sel=1.
  - With br_true=0: pc_we=0.
  - Either way the next state is FETCH.
- lw (0x0000A183) with mem_ready low for 3 cycles in MEM.
  - Response: mem_req=1 and iord=1 held for 4 cycles. rf_we=1 and wb_sel=1 only in the ready cycle.
- ir=0x0000A033 (slt): after DECODE, TRAP with illegal=1 and all enables 0. It stays there for 10 cycles with trap_clr=0. rst then returns it to FETCH.
- rst pulsed during MEM of sw: mem_req and mem_we drop in the rst cycle. The state is FETCH on the next cycle with mem_req=1 and iord=0.
